// File: rtl/spi_pkg.sv
// Shared definitions for the MOSI receive path: FSM encodings, default byte width
// and the broadcast address.
package spi_pkg;

  localparam int DSIZE_DEF = 8;
  localparam logic [DSIZE_DEF-1:0] BCAST_ADDR = {DSIZE_DEF{1'b1}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } rx_state_e;

endpackage

// File: rtl/spi_rx_fifo.sv
// Synchronous first-word-fall-through frame FIFO; dout shows the head entry and
// reads as zero while empty. A push into a full FIFO is accepted only alongside a pop.
module spi_rx_fifo #(
  parameter int WIDTH      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          spi_clk,
  input  logic                          n_reset,
  input  logic                          push,
  input  logic                          pop,
  input  logic [WIDTH-1:0]              din,
  output logic [WIDTH-1:0]              dout,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          full,
  output logic                          empty
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt;
  logic             do_push;
  logic             do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == (AW+1)'(FIFO_DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge spi_clk or negedge n_reset) begin
    if (!n_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge spi_clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  assign dout  = empty ? '0 : mem[rd_ptr];
  assign count = cnt;

endmodule

// File: rtl/spi_mosi_rx.sv
// Slave-side MOSI deserializer: rebuilds LSB-first {address, data} frames and queues them.
// Optional build macro ADDR_FILTER_EN keeps only frames for my_addr or the broadcast address.
module spi_mosi_rx
  import spi_pkg::*;
#(
  parameter int DSIZE      = DSIZE_DEF,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          spi_clk,
  input  logic                          n_reset,
  input  logic                          spi_cs,
  input  logic                          spi_mosi,
  input  logic [DSIZE-1:0]              my_addr,
  input  logic                          rx_rd_en,
  input  logic                          ovr_clr,
  output logic [DSIZE-1:0]              rx_addr,
  output logic [DSIZE-1:0]              rx_data,
  output logic                          rx_valid,
  output logic [$clog2(FIFO_DEPTH):0]   rx_count,
  output logic                          rx_overrun,
  output logic                          frame_err
);

  localparam int            CW   = $clog2(DSIZE);
  localparam logic [CW-1:0] LAST = CW'(DSIZE - 1);

  rx_state_e        state, state_nxt;
  logic [CW-1:0]    bit_cnt, bit_cnt_nxt;
  logic [DSIZE-2:0] shift_reg, shift_nxt;
  logic [DSIZE-1:0] addr_reg, addr_nxt;
  logic             frame_done;
  logic             frame_err_nxt;
  logic             addr_ok;
  logic             push_req;
  logic             fifo_full;
  logic             fifo_empty;
  logic [DSIZE-1:0] frame_data;

  // The top bit of each byte is taken straight from the line, so the shifter holds DSIZE-1 bits.
  assign frame_data = {spi_mosi, shift_reg};

  always_ff @(posedge spi_clk or negedge n_reset) begin
    if (!n_reset) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shift_reg <= '0;
      addr_reg  <= '0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      bit_cnt   <= bit_cnt_nxt;
      shift_reg <= shift_nxt;
      addr_reg  <= addr_nxt;
      frame_err <= frame_err_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    bit_cnt_nxt   = bit_cnt;
    shift_nxt     = shift_reg;
    addr_nxt      = addr_reg;
    frame_done    = 1'b0;
    frame_err_nxt = 1'b0;
    if (spi_cs) begin
      state_nxt     = IDLE;
      bit_cnt_nxt   = '0;
      frame_err_nxt = ((state == ADDR) && (bit_cnt != '0)) || (state == DATA);
    end else begin
      for (int i = 0; i < DSIZE - 1; i++) begin
        if (bit_cnt == CW'(i)) shift_nxt[i] = spi_mosi;
      end
      case (state)
        IDLE: begin
          state_nxt   = ADDR;
          bit_cnt_nxt = CW'(1);
        end
        ADDR: begin
          if (bit_cnt == LAST) begin
            addr_nxt    = frame_data;
            state_nxt   = DATA;
            bit_cnt_nxt = '0;
          end else begin
            bit_cnt_nxt = bit_cnt + 1'b1;
          end
        end
        DATA: begin
          if (bit_cnt == LAST) begin
            frame_done  = 1'b1;
            state_nxt   = ADDR;
            bit_cnt_nxt = '0;
          end else begin
            bit_cnt_nxt = bit_cnt + 1'b1;
          end
        end
        default: begin
          state_nxt   = IDLE;
          bit_cnt_nxt = '0;
        end
      endcase
    end
  end

`ifdef ADDR_FILTER_EN
  assign addr_ok = (addr_reg == my_addr) || (addr_reg == {DSIZE{1'b1}});
`else
  logic unused_my_addr;
  assign unused_my_addr = ^my_addr;
  assign addr_ok        = 1'b1;
`endif

  assign push_req = frame_done & addr_ok;

  // A concurrent pop frees the slot, so only an unpaired push into a full FIFO is a loss.
  always_ff @(posedge spi_clk or negedge n_reset) begin
    if (!n_reset) begin
      rx_overrun <= 1'b0;
    end else if (push_req && fifo_full && !(rx_rd_en && !fifo_empty)) begin
      rx_overrun <= 1'b1;
    end else if (ovr_clr) begin
      rx_overrun <= 1'b0;
    end
  end

  spi_rx_fifo #(
    .WIDTH      (2 * DSIZE),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .spi_clk (spi_clk),
    .n_reset (n_reset),
    .push    (push_req),
    .pop     (rx_rd_en),
    .din     ({addr_reg, frame_data}),
    .dout    ({rx_addr, rx_data}),
    .count   (rx_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign rx_valid = ~fifo_empty;

endmodule
